// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
//   mem_owner_t  : owner tag carried by each in-flight RAM read
//   STARVE_CNT_W : width of the instruction starvation counter
//   flush_kill   : clears an instruction owner tag when a flush is active
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } mem_owner_t;

  localparam int unsigned STARVE_CNT_W = 4;

  // A flushed instruction read still occupies its RAM slot, but its data is dropped.
  function automatic mem_owner_t flush_kill(input mem_owner_t own, input logic flush);
    return (flush && (own == OWN_I)) ? OWN_NONE : own;
  endfunction

endpackage

// File: rtl/mem_resp_tracker.sv
// Owner pipeline that matches returning RAM read data to the port that issued it.
//   clk, rst      : clock, async active-low reset
//   flush_i       : kills every in-flight instruction entry, including this cycle's insert
//   ins_owner_i   : owner of the access granted this cycle (OWN_NONE for writes/idle)
//   i_rvalid_o    : tail entry belongs to the instruction port (masked by flush)
//   d_rvalid_o    : tail entry belongs to the data port
module mem_resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic [1:0] ins_owner_i,
  output logic       i_rvalid_o,
  output logic       d_rvalid_o
);

  mem_owner_t own_q [MEM_LAT];
  mem_owner_t own_d [MEM_LAT];

  // Shift towards the tail; flush scrubs instruction tags on the way.
  always_comb begin
    own_d    = '{default: OWN_NONE};
    own_d[0] = flush_kill(mem_owner_t'(ins_owner_i), flush_i);
    for (int k = 1; k < int'(MEM_LAT); k++) begin
      own_d[k] = flush_kill(own_q[k-1], flush_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < int'(MEM_LAT); k++) begin
        own_q[k] <= OWN_NONE;
      end
    end else begin
      for (int k = 0; k < int'(MEM_LAT); k++) begin
        own_q[k] <= own_d[k];
      end
    end
  end

  // The tail entry lines up with mem_rdata; flush suppresses an instruction return immediately.
  assign i_rvalid_o = (own_q[MEM_LAT-1] == OWN_I) && !flush_i;
  assign d_rvalid_o = (own_q[MEM_LAT-1] == OWN_D);

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the instruction fetch port (read-only)
// and the data port (read/write). Data wins ties until STARVE_LIMIT consecutive data grants
// have been given while an instruction request waited; then the instruction port is forced.
//   clk, rst                          : clock, async active-low reset
//   i_req/i_addr -> i_gnt             : instruction request and same-cycle grant
//   i_rvalid/i_rdata                  : instruction read return, MEM_LAT cycles after grant
//   d_req/d_we/d_addr/d_wdata/d_be    : data request, d_gnt is the same-cycle grant
//   d_rvalid/d_rdata                  : data read return, MEM_LAT cycles after grant
//   flush                             : drop in-flight instruction returns
//   mem_*                             : RAM macro interface
module memory_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                flush,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  // Elaboration-time parameter legality.
  if ((DATA_W == 0) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
    $error("memory_port_arbiter: DATA_W must be a non-zero multiple of 8");
  end
  if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_bad_mem_lat
    $error("memory_port_arbiter: MEM_LAT must be in 1..4");
  end
  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_starve
    $error("memory_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

  logic [STARVE_CNT_W-1:0] starve_q;
  logic [STARVE_CNT_W-1:0] starve_d;
  logic                    starved;
  mem_owner_t              ins_owner;

  assign starved = (starve_q == STARVE_CNT_W'(STARVE_LIMIT));

  // Same-cycle grant; nothing is granted while reset is held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (d_req && !(i_req && starved)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  // Counts data grants that overtook a waiting instruction request; saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    if (!i_req || i_gnt || flush) begin
      starve_d = '0;
    end else if (d_gnt && !starved) begin
      starve_d = starve_q + STARVE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // RAM request mux from the granted port.
  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_be    = '1;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr = d_addr;
      if (d_we) begin
        mem_be    = d_be;
        mem_wdata = d_wdata;
      end
    end else if (i_gnt) begin
      mem_addr = i_addr;
    end
  end

  // Writes complete at grant and never produce a return.
  always_comb begin
    ins_owner = OWN_NONE;
    if (d_gnt && !d_we) begin
      ins_owner = OWN_D;
    end else if (i_gnt) begin
      ins_owner = OWN_I;
    end
  end

  mem_resp_tracker #(
    .MEM_LAT (MEM_LAT)
  ) u_resp_tracker (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .ins_owner_i (ins_owner),
    .i_rvalid_o  (i_rvalid),
    .d_rvalid_o  (d_rvalid)
  );

  assign i_rdata = i_rvalid ? mem_rdata : {BE_W{8'h00}};
  assign d_rdata = d_rvalid ? mem_rdata : {BE_W{8'h00}};

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=2) share one stimulus
// stream, each backed by its own behavioural RAM. A transaction-level model predicts grants,
// RAM commands and returned data for every cycle.
module tb_memory_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = DW / 8;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          i_req   = 1'b0;
  logic          d_req   = 1'b0;
  logic          d_we    = 1'b0;
  logic          flush   = 1'b0;
  logic [AW-1:0] i_addr  = '0;
  logic [AW-1:0] d_addr  = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be    = '0;

  logic [1:0]         i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we;
  logic [1:0][DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [1:0][AW-1:0] mem_addr;
  logic [1:0][BW-1:0] mem_be;
  logic [DW-1:0]      rd_l1;
  logic [1:0][DW-1:0] rd_l2;

  memory_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_LIMIT(LIM)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .flush(flush),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_be(mem_be[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(rd_l1)
  );

  memory_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .STARVE_LIMIT(LIM)) u_dut_l2 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .flush(flush),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_be(mem_be[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(rd_l2[1])
  );

  // Behavioural RAMs: 256 words indexed by addr[9:2], read data after 1 / 2 cycles.
  logic [DW-1:0] ram_l1 [256];
  logic [DW-1:0] ram_l2 [256];
  logic          seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) begin
        ram_l1[i] <= '0;
        ram_l2[i] <= '0;
      end
      ram_l1[0] <= 32'h0000_0013; ram_l1[1] <= 32'h0010_0093; ram_l1[2] <= 32'h0020_0113;
      ram_l2[0] <= 32'h0000_0013; ram_l2[1] <= 32'h0010_0093; ram_l2[2] <= 32'h0020_0113;
      seeded <= 1'b1;
    end
    rd_l1    <= 32'hBAD0_BAD0;
    rd_l2[0] <= 32'hBAD0_BAD0;
    rd_l2[1] <= rd_l2[0];
    if (mem_en[0]) begin
      if (mem_we[0]) begin
        for (int b = 0; b < int'(BW); b++)
          if (mem_be[0][b]) ram_l1[mem_addr[0][9:2]][8*b +: 8] <= mem_wdata[0][8*b +: 8];
      end else begin
        rd_l1 <= ram_l1[mem_addr[0][9:2]];
      end
    end
    if (mem_en[1]) begin
      if (mem_we[1]) begin
        for (int b = 0; b < int'(BW); b++)
          if (mem_be[1][b]) ram_l2[mem_addr[1][9:2]][8*b +: 8] <= mem_wdata[1][8*b +: 8];
      end else begin
        rd_l2[0] <= ram_l2[mem_addr[1][9:2]];
      end
    end
  end

  // Reference model: pending reads as a queue of (owner, data, due cycle) per latency.
  typedef struct {
    logic          is_i;
    logic [DW-1:0] data;
    int unsigned   due;
  } resp_t;
  typedef resp_t rq_t[$];

  rq_t           q_l1, q_l2;
  logic [DW-1:0] ref_mem [256];
  int unsigned   streak = 0;
  int unsigned   cyc    = 0;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          exp_ig = 1'b0, exp_dg = 1'b0;

  // Observations captured by step() for the directed checks.
  logic          ob_ig, ob_dg;
  logic [3:0]    ob_rv;
  logic          ob_irv_l2, ob_drv_l2;
  logic [DW-1:0] ob_drd_l2;
  logic [DW-1:0] seen_i[$];
  logic [DW-1:0] last_drd_l1, last_drd_l2;
  int            n_drv_l1;

  function automatic rq_t drop_i(input rq_t q);
    rq_t r;
    foreach (q[j]) if (!q[j].is_i) r.push_back(q[j]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_inst(input int k, input logic has, input resp_t h);
    string p;
    logic  ev_i, ev_d;
    p    = (k == 0) ? "L1" : "L2";
    ev_i = has && h.is_i;
    ev_d = has && !h.is_i;
    chk({p, " i_gnt"},    DW'(i_gnt[k]),  DW'(exp_ig));
    chk({p, " d_gnt"},    DW'(d_gnt[k]),  DW'(exp_dg));
    chk({p, " mem_en"},   DW'(mem_en[k]), DW'(exp_ig | exp_dg));
    chk({p, " mem_we"},   DW'(mem_we[k]), DW'(exp_dg & d_we));
    if (exp_ig || exp_dg) chk({p, " mem_addr"}, DW'(mem_addr[k]), DW'(exp_dg ? d_addr : i_addr));
    chk({p, " i_rvalid"}, DW'(i_rvalid[k]), DW'(ev_i));
    chk({p, " i_rdata"},  i_rdata[k], ev_i ? h.data : '0);
    chk({p, " d_rvalid"}, DW'(d_rvalid[k]), DW'(ev_d));
    chk({p, " d_rdata"},  d_rdata[k], ev_d ? h.data : '0);
  endtask

  // One clock cycle: inputs were set at the preceding negedge.
  task automatic step();
    resp_t h1, h2, nr;
    logic  has1, has2;
    #1;
    if (!rst) begin
      exp_ig = 1'b0;
      exp_dg = 1'b0;
      streak = 0;
      q_l1.delete();
      q_l2.delete();
    end else begin
      exp_dg = d_req && (!i_req || streak < LIM);
      exp_ig = i_req && !exp_dg;
      if (flush) begin
        q_l1 = drop_i(q_l1);
        q_l2 = drop_i(q_l2);
      end
    end
    has1 = (q_l1.size() > 0) && (q_l1[0].due == cyc);
    has2 = (q_l2.size() > 0) && (q_l2[0].due == cyc);
    if (has1) h1 = q_l1[0]; else h1 = '{1'b0, '0, 0};
    if (has2) h2 = q_l2[0]; else h2 = '{1'b0, '0, 0};
    chk_inst(0, has1, h1);
    chk_inst(1, has2, h2);
    if (has1) void'(q_l1.pop_front());
    if (has2) void'(q_l2.pop_front());

    ob_ig     = i_gnt[0];
    ob_dg     = d_gnt[0];
    ob_rv     = {i_rvalid, d_rvalid};
    ob_irv_l2 = i_rvalid[1];
    ob_drv_l2 = d_rvalid[1];
    ob_drd_l2 = d_rdata[1];
    if (i_rvalid[0]) seen_i.push_back(i_rdata[0]);
    if (d_rvalid[0]) begin last_drd_l1 = d_rdata[0]; n_drv_l1++; end
    if (d_rvalid[1]) last_drd_l2 = d_rdata[1];

    if (rst) begin
      if (exp_dg && d_we) begin
        for (int b = 0; b < int'(BW); b++)
          if (d_be[b]) ref_mem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
      end else if (exp_dg || (exp_ig && !flush)) begin
        nr.is_i = exp_ig;
        nr.data = ref_mem[exp_dg ? d_addr[9:2] : i_addr[9:2]];
        nr.due  = cyc + 1;
        q_l1.push_back(nr);
        nr.due  = cyc + 2;
        q_l2.push_back(nr);
      end
      if (!i_req || exp_ig || flush) streak = 0;
      else if (exp_dg && streak < LIM) streak++;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [9:0]    gseq;
    logic [DW-1:0] exp_prog [3];
    exp_prog[0] = 32'h0000_0013;
    exp_prog[1] = 32'h0010_0093;
    exp_prog[2] = 32'h0020_0113;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 3; i++) ref_mem[i] = exp_prog[i];

    // Reset held with both ports requesting.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h0; d_addr = 32'h4;
    @(negedge clk);
    step();
    chk("reset outputs", DW'({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en}), '0);
    step();
    rst = 1'b1;
    step();
    chk("first grant after reset", DW'({ob_ig, ob_dg}), DW'(2'b01));

    // Instruction-only stream.
    d_req = 1'b0; i_req = 1'b0;
    step();
    seen_i.delete();
    i_req = 1'b1;
    for (int j = 0; j < 3; j++) begin
      i_addr = 32'(4 * j);
      step();
    end
    i_req = 1'b0;
    step(); step();
    chk("ionly return count", DW'(seen_i.size()), DW'(3));
    for (int j = 0; j < 3; j++)
      chk($sformatf("ionly data %0d", j), (j < seen_i.size()) ? seen_i[j] : '0, exp_prog[j]);

    // Priority with starvation relief.
    i_req = 1'b1; i_addr = 32'hC; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    gseq = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      gseq[j] = ob_ig;
    end
    chk("starvation sequence", DW'(gseq), DW'(10'h210));
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step();

    // Byte-masked write then read back.
    last_drd_l1 = '0; last_drd_l2 = '0; n_drv_l1 = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    step();
    d_we = 1'b0;
    step();
    d_req = 1'b0;
    step(); step(); step();
    chk("write+read d_rvalid count", DW'(n_drv_l1), DW'(1));
    chk("masked read L1", last_drd_l1, 32'h0000_BEEF);
    chk("masked read L2", last_drd_l2, 32'h0000_BEEF);

    // Flush kills an in-flight instruction read but not a data read.
    i_req = 1'b1; i_addr = 32'h4;
    step();
    i_req = 1'b0; flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    step();
    flush = 1'b0; d_req = 1'b0;
    step();
    chk("flush L2 i_rvalid", DW'(ob_irv_l2), '0);
    step();
    chk("flush L2 d_rvalid", DW'(ob_drv_l2), DW'(1));
    chk("flush L2 d_rdata", ob_drd_l2, 32'h0020_0113);
    step();

    // Reset while reads are in flight with a partly built starvation streak.
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0;
    step(); step(); step();
    #1 rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    gseq = '0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (j == 0) chk("no rvalid after reset", DW'(ob_rv), '0);
      gseq[j] = ob_ig;
    end
    chk("post-reset starvation sequence", DW'(gseq), DW'(10'h210));
    i_req = 1'b0; d_req = 1'b0;
    step(); step(); step();

    // Randomised traffic; requests are held until the model says they were granted.
    for (int n = 0; n < 600; n++) begin
      if (!i_req || exp_ig) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = $urandom;
      end
      if (!d_req || exp_dg) begin
        d_req   = $urandom_range(0, 1) == 1;
        d_we    = $urandom_range(0, 1) == 1;
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = BW'($urandom);
      end
      flush = ($urandom_range(0, 15) == 0);
      step();
    end
    i_req = 1'b0; d_req = 1'b0; flush = 1'b0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
